// File: rtl/data_mem_ctrl_if.sv
// CPU-side data memory bus: load/store strobes, byte address and data,
// plus the stall/done/error status returned by the memory controller.
interface data_mem_ctrl_if;
    logic        MEMREAD;
    logic        MEMWRITE;
    logic [63:0] ADDRESS;
    logic [63:0] WRITE_DATA;
    logic [63:0] READ_DATA;
    logic        STALL;
    logic        DONE;
    logic        ERROR;

    modport master (
        output MEMREAD, MEMWRITE, ADDRESS, WRITE_DATA,
        input  READ_DATA, STALL, DONE, ERROR
    );

    modport slave (
        input  MEMREAD, MEMWRITE, ADDRESS, WRITE_DATA,
        output READ_DATA, STALL, DONE, ERROR
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle 64-bit word data memory with IDLE/BUSY/FINISH access FSM,
// request validation and a registered load-data output.
module data_mem_ctrl #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    data_mem_ctrl_if.slave   bus
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [60:0] DEPTH_W  = 61'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [63:0]      wdata_q;
    logic [63:0]      rdata_q;
    logic             done_q;
    logic             error_q;
    logic [63:0]      mem_q [DEPTH];

    logic req_any;
    logic req_valid;

    always_comb begin
        req_any   = bus.MEMREAD | bus.MEMWRITE;
        req_valid = (bus.MEMREAD ^ bus.MEMWRITE) &&
                    (bus.ADDRESS[2:0] == 3'b000) &&
                    (bus.ADDRESS[63:3] < DEPTH_W);
    end

    // STALL must rise in the request cycle itself so the CPU holds its PC.
    assign bus.STALL      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    assign bus.READ_DATA  = rdata_q;
    assign bus.DONE       = done_q;
    assign bus.ERROR      = error_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= bus.MEMWRITE;
                        idx_q   <= bus.ADDRESS[3 +: IDX_W];
                        wdata_q <= bus.WRITE_DATA;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end else if (req_any) begin
                        error_q <= 1'b1;
                    end
                end
                BUSY: begin
                    // The memory is touched only on the final BUSY edge, so a reset
                    // anywhere inside BUSY discards the access entirely.
                    if (cnt_q == 4'd0) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        if (wr_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end else begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 64-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, number of BUSY cycles per access; legal range 1..15.
REQ-003 SHALL have port CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MEMREAD  input  1  read request, driven by the CPU control unit.
REQ-006 SHALL have port MEMWRITE  input  1  write request, driven by the CPU control unit.
REQ-007 SHALL have port ADDRESS  input  64  byte address, driven by the CPU ALU result.
REQ-008 SHALL have port WRITE_DATA  input  64  store data, driven by register read port 2.
REQ-009 SHALL have port READ_DATA  output  64  load data, fed to the CPU data_memory_out input.
REQ-010 SHALL have port STALL  output  1  high while the CPU must hold PC and its control outputs.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse on access completion.
REQ-012 SHALL have port ERROR  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 SHALL implement states IDLE, BUSY and FINISH.
REQ-014 SHALL treat a request as valid only when all of these hold:
- exactly one of MEMREAD and MEMWRITE is high;
- ADDRESS[2:0] == 0;
- ADDRESS[63:3] < DEPTH.
REQ-015 In IDLE with a valid request, SHALL on the clock edge:
- capture the operation, word index ADDRESS[63:3] and WRITE_DATA;
- load the down-counter with LATENCY-1;
- move to BUSY.
REQ-016 In IDLE with a request that is not valid (both strobes high, misaligned, or out of range), SHALL:
- stay in IDLE;
- perform no memory access;
- assert ERROR for exactly the next cycle.
REQ-017 In BUSY, SHALL decrement the counter each cycle; when the counter is 0, SHALL move to FINISH on that edge, so BUSY lasts exactly LATENCY cycles.
REQ-018 On the BUSY->FINISH edge, SHALL write the captured data to the captured word (write) or load that word into the READ_DATA register (read).
REQ-019 In FINISH, SHALL assert DONE for one cycle, ignore MEMREAD and MEMWRITE, and return to IDLE.
REQ-020 SHALL drive STALL combinationally: high when (IDLE and valid request) or BUSY; low in FINISH, when idle, and for invalid requests.
REQ-021 SHALL give a total access latency of LATENCY+1 cycles from the request cycle to the DONE cycle, with READ_DATA valid in the DONE cycle.
REQ-022 SHALL hold READ_DATA at its last loaded value until the next read completes; writes and errors SHALL NOT change it.
REQ-023 SHALL ignore changes to ADDRESS and WRITE_DATA after acceptance; only the captured values are used.
REQ-024 SHALL use only ADDRESS[63:3] for indexing; no sub-word or byte-lane access.
REQ-025 SHALL keep DONE and ERROR mutually exclusive in every cycle.

Reset
REQ-026 While RESET is high at a clock edge, SHALL apply:
- state IDLE, counter 0;
- READ_DATA = 0, DONE = 0, ERROR = 0;
- all DEPTH words cleared to 0.
REQ-027 A RESET during BUSY SHALL abort the access: a pending write is discarded and no DONE is produced.
REQ-028 STALL SHALL be 0 in the cycle after reset, unless a valid request is present.
REQ-029 RESET SHALL take priority over any simultaneous request.

Verification
REQ-030 Write then read, LATENCY=2:
- MEMWRITE, ADDRESS=0x10, WRITE_DATA=0xDEADBEEF_CAFEF00D -> STALL high for 3 cycles, DONE in cycle 3;
- then MEMREAD of 0x10 -> READ_DATA=0xDEADBEEF_CAFEF00D with DONE in cycle 3.
REQ-031 MEMREAD with ADDRESS=0x0C -> ERROR pulse the next cycle, STALL low, no DONE, READ_DATA unchanged.
REQ-032 MEMREAD and MEMWRITE both high -> ERROR pulse, memory unchanged; ADDRESS=DEPTH*8 -> ERROR pulse.
REQ-033 MEMWRITE of 0x5555 to 0x08, RESET asserted in the first BUSY cycle -> no DONE; a subsequent read of 0x08 returns 0.
REQ-034 Write 0x1 to 0x00, then change ADDRESS to 0x08 and WRITE_DATA to 0x2 during BUSY -> reads return word0=0x1 and word1=0.
REQ-035 LATENCY=1: back-to-back writes to 0x00 and 0x08 -> each completes in 2 cycles; the request held during the FINISH cycle is accepted in the following IDLE cycle.
